wb_arb2: RTL and testbench

- Two-master, one-slave Wishbone arbiter that shares a single slave (typically the on-chip wb_ram) between two requesters, e.g. the CPU data port and a DMA or debug master.
- Registered round-robin grant; a grant is held for the whole cycle, i.e. while the granted master keeps cyc high.
- Address, data, select and write-enable of the granted master are muxed to the slave.
- Slave ack/err is routed back to the granted master only.

---
 rtl/wb_arb2.sv | 144 ++++++++++++++
 tb/tb_wb_arb2.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2.sv
// Two-master, one-slave Wishbone arbiter with registered round-robin grant.
// Optional slave-timeout error generation is enabled with WB_ARB_TIMEOUT_EN.
module wb_arb2 #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,

    output logic [1:0]      gnt_o
);

    typedef enum logic [1:0] {StIdle = 2'd0, StG0 = 2'd1, StG1 = 2'd2} state_e;

    state_e state_q;
    logic   last_q;
    logic   to_fire;

    // last_q names the master that released most recently; the other one wins a tie.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        state_q <= last_q ? StG0 : StG1;
                    end else if (m0_cyc_i) begin
                        state_q <= StG0;
                    end else if (m1_cyc_i) begin
                        state_q <= StG1;
                    end
                end
                StG0: begin
                    if (!m0_cyc_i) begin
                        last_q  <= 1'b0;
                        state_q <= m1_cyc_i ? StG1 : StIdle;
                    end
                end
                StG1: begin
                    if (!m1_cyc_i) begin
                        last_q  <= 1'b1;
                        state_q <= m0_cyc_i ? StG0 : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        gnt_o   = 2'b00;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        case (state_q)
            StG0: begin
                gnt_o   = 2'b01;
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            StG1: begin
                gnt_o   = 2'b10;
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CntRaw = $clog2(TIMEOUT + 1);
    localparam int unsigned CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 32) ? 32 : CntRaw);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    logic [CntW-1:0] wait_cnt_q;

    assign to_fire = (wait_cnt_q == CntMax);

    // Counts strobed cycles the slave leaves unanswered; firing restarts the count.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_q == StIdle || s_ack_i || s_err_i || to_fire) begin
            wait_cnt_q <= '0;
        end else if (s_stb_o) begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign to_fire        = 1'b0;
`endif

    assign m0_ack_o = s_ack_i & (state_q == StG0);
    assign m1_ack_o = s_ack_i & (state_q == StG1);
    assign m0_err_o = (s_err_i | to_fire) & (state_q == StG0);
    assign m1_err_o = (s_err_i | to_fire) & (state_q == StG1);
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arb2.sv
// Self-checking bench for wb_arb2: directed vector table, hand-written corner
// sequences and a randomized run against an ownership-level reference model.
module tb_wb_arb2;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic           clk;
    logic           rst;
    logic           mc   [2];
    logic           ms   [2];
    logic           mw   [2];
    logic [3:0]     msel [2];
    logic [AW-1:0]  madr [2];
    logic [DW-1:0]  mdat [2];
    logic [DW-1:0]  m0_dat, m1_dat;
    logic           m0_ack, m1_ack, m0_err, m1_err;
    logic           s_cyc, s_stb, s_we;
    logic [3:0]     s_sel;
    logic [AW-1:0]  s_adr;
    logic [DW-1:0]  s_dat_o, s_dat_i;
    logic           s_ack, s_err;
    logic [1:0]     gnt;

    int n_checks = 0;
    int n_fail   = 0;

    wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0_cyc_i (mc[0]), .m0_stb_i (ms[0]), .m0_we_i (mw[0]), .m0_sel_i (msel[0]),
        .m0_adr_i (madr[0]), .m0_dat_i (mdat[0]), .m0_dat_o (m0_dat),
        .m0_ack_o (m0_ack), .m0_err_o (m0_err),
        .m1_cyc_i (mc[1]), .m1_stb_i (ms[1]), .m1_we_i (mw[1]), .m1_sel_i (msel[1]),
        .m1_adr_i (madr[1]), .m1_dat_i (mdat[1]), .m1_dat_o (m1_dat),
        .m1_ack_o (m1_ack), .m1_err_o (m1_err),
        .s_cyc_o  (s_cyc), .s_stb_o (s_stb), .s_we_o (s_we), .s_sel_o (s_sel),
        .s_adr_o  (s_adr), .s_dat_o (s_dat_o), .s_dat_i (s_dat_i),
        .s_ack_i  (s_ack), .s_err_i (s_err),
        .gnt_o    (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_m(input int i, input logic c, input logic s, input logic w);
        mc[i] = c;
        ms[i] = s;
        mw[i] = w;
    endtask

    // Reference model: who owns the slave, who released last, unanswered-strobe count.
    int owner;
    int last;
    int wcnt;

    function automatic logic model_fire();
`ifdef WB_ARB_TIMEOUT_EN
        return wcnt == TO;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_check();
        logic [1:0] e_gnt;
        logic       e_stb;
        logic       fire;
        e_gnt = (owner < 0) ? 2'b00 : 2'(1 << owner);
        fire  = model_fire();
        chk("rnd_gnt", 64'(gnt), 64'(e_gnt));
        if (owner < 0) begin
            chk("rnd_s_cyc", 64'(s_cyc), 64'd0);
            chk("rnd_s_stb", 64'(s_stb), 64'd0);
            chk("rnd_s_adr", 64'(s_adr), 64'd0);
        end else begin
            e_stb = ms[owner];
            chk("rnd_s_cyc", 64'(s_cyc), 64'(mc[owner]));
            chk("rnd_s_stb", 64'(s_stb), 64'(e_stb));
            chk("rnd_s_we", 64'(s_we), 64'(mw[owner]));
            chk("rnd_s_sel", 64'(s_sel), 64'(msel[owner]));
            chk("rnd_s_adr", 64'(s_adr), 64'(madr[owner]));
            chk("rnd_s_dat", 64'(s_dat_o), 64'(mdat[owner]));
        end
        chk("rnd_m0_ack", 64'(m0_ack), 64'(s_ack && owner == 0));
        chk("rnd_m1_ack", 64'(m1_ack), 64'(s_ack && owner == 1));
        chk("rnd_m0_err", 64'(m0_err), 64'((s_err || fire) && owner == 0));
        chk("rnd_m1_err", 64'(m1_err), 64'((s_err || fire) && owner == 1));
        chk("rnd_m0_dat", 64'(m0_dat), 64'(s_dat_i));
        chk("rnd_m1_dat", 64'(m1_dat), 64'(s_dat_i));
    endtask

    task automatic model_step();
        logic stb_out;
        if (rst) begin
            owner = -1;
            last  = 1;
            wcnt  = 0;
            return;
        end
        stb_out = (owner >= 0) && ms[owner];
        if (owner < 0 || s_ack || s_err || model_fire()) wcnt = 0;
        else if (stb_out) wcnt++;
        if (owner < 0) begin
            if (mc[0] && mc[1]) owner = 1 - last;
            else if (mc[0]) owner = 0;
            else if (mc[1]) owner = 1;
        end else if (!mc[owner]) begin
            last  = owner;
            owner = mc[1 - owner] ? 1 - owner : -1;
        end
    endtask

    typedef struct packed {
        logic       c0, s0, c1, s1, ack;
        logic [1:0] gnt;
        logic       sstb, a0, a1;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int acks;
        int k;
        int first_err;
        int pulses;

        // c0 s0 c1 s1 ack | gnt stb a0 a1 ; one row per cycle, starting from reset
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        s_ack = 1'b0;
        s_err = 1'b0;
        s_dat_i = 32'h0;
        for (int i = 0; i < 2; i++) begin
            set_m(i, 1'b0, 1'b0, 1'b0);
            msel[i] = 4'h0;
            madr[i] = '0;
            mdat[i] = '0;
        end
        repeat (2) @(negedge clk);
        s_ack = 1'b1;
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_s_cyc", 64'(s_cyc), 64'd0);
        chk("rst_s_stb", 64'(s_stb), 64'd0);
        chk("rst_s_we", 64'(s_we), 64'd0);
        chk("rst_s_adr", 64'(s_adr), 64'd0);
        chk("rst_s_sel", 64'(s_sel), 64'd0);
        chk("rst_s_dat", 64'(s_dat_o), 64'd0);
        chk("rst_acks", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'd0);

        // Directed table: tie-break after reset, handover, round-robin both ways.
        @(negedge clk);
        rst = 1'b0;
        madr[0] = 32'h10;
        madr[1] = 32'h44;
        for (int r = 0; r < 13; r++) begin
            if (r > 0) @(negedge clk);
            set_m(0, vecs[r].c0, vecs[r].s0, 1'b0);
            set_m(1, vecs[r].c1, vecs[r].s1, 1'b0);
            s_ack = vecs[r].ack;
            #1;
            chk($sformatf("vec%0d_gnt", r), 64'(gnt), 64'(vecs[r].gnt));
            chk($sformatf("vec%0d_s_stb", r), 64'(s_stb), 64'(vecs[r].sstb));
            chk($sformatf("vec%0d_m0_ack", r), 64'(m0_ack), 64'(vecs[r].a0));
            chk($sformatf("vec%0d_m1_ack", r), 64'(m1_ack), 64'(vecs[r].a1));
        end

        // Four-beat m0 write burst while m1 waits; m1 must follow with no idle cycle.
        @(negedge clk);
        set_m(0, 1'b1, 1'b1, 1'b1);
        msel[0] = 4'b0011;
        madr[0] = 32'h20;
        mdat[0] = 32'hA5A5_1234;
        set_m(1, 1'b1, 1'b1, 1'b0);
        s_ack = 1'b0;
        #1;
        chk("burst_req_gnt", 64'(gnt), 64'd0);
        acks = 0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            s_ack = 1'b1;
            #1;
            chk("burst_gnt", 64'(gnt), 64'd1);
            chk("burst_s_we", 64'(s_we), 64'd1);
            chk("burst_s_sel", 64'(s_sel), 64'h3);
            chk("burst_s_dat", 64'(s_dat_o), 64'hA5A5_1234);
            chk("burst_m1_ack", 64'(m1_ack), 64'd0);
            if (m0_ack) acks++;
        end
        chk("burst_m0_acks", 64'(acks), 64'd4);
        @(negedge clk);
        set_m(0, 1'b0, 1'b0, 1'b0);
        s_ack = 1'b0;
        #1;
        chk("burst_release_gnt", 64'(gnt), 64'd1);
        @(negedge clk);
        #1;
        chk("handover_gnt", 64'(gnt), 64'd2);

        // Reset while m1 has a write in flight: transfer abandoned, no ack.
        @(negedge clk);
        mw[1] = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_mid_gnt_before", 64'(gnt), 64'd2);
        @(negedge clk);
        rst = 1'b0;
        s_ack = 1'b1;
        #1;
        chk("rst_mid_gnt", 64'(gnt), 64'd0);
        chk("rst_mid_s_cyc", 64'(s_cyc), 64'd0);
        chk("rst_mid_m1_ack", 64'(m1_ack), 64'd0);
        @(negedge clk);
        set_m(1, 1'b0, 1'b0, 1'b0);
        s_ack = 1'b0;

        // Silent slave: error pulse only when the timeout option is built in.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b0);
        k = -1;
        first_err = -1;
        pulses = 0;
        for (int c = 0; c < 17; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (s_stb && k < 0) k = c;
            if (m0_err) begin
                pulses++;
                if (first_err < 0) first_err = c;
            end
            chk("to_m1_err", 64'(m1_err), 64'd0);
        end
`ifdef WB_ARB_TIMEOUT_EN
        chk("to_delay", 64'(first_err - k), 64'(TO));
        chk("to_pulses", 64'(pulses), 64'd1);
`else
        chk("to_pulses", 64'(pulses), 64'd0);
`endif
        @(negedge clk);
        set_m(0, 1'b0, 1'b0, 1'b0);

        // Randomized run against the model.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        owner = -1;
        last  = 1;
        wcnt  = 0;
        for (int t = 0; t < 600; t++) begin
            if (t > 0) @(negedge clk);
            rst = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < 2; i++) begin
                if (mc[i]) mc[i] = ($urandom_range(0, 5) != 0);
                else mc[i] = ($urandom_range(0, 2) == 0);
                ms[i]   = mc[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                mw[i]   = 1'($urandom);
                msel[i] = 4'($urandom);
                madr[i] = $urandom;
                mdat[i] = $urandom;
            end
            s_ack   = ($urandom_range(0, 3) == 0);
            s_err   = ($urandom_range(0, 15) == 0);
            s_dat_i = $urandom;
            #1;
            model_check();
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
